// File: rtl/sort4_controller_pkg.sv
// Shared definitions for the 4-element bubble-sort controller: FSM encoding
// and element/count sizing used by the top level and the comparator.
package sort4_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_ELEM    = 4;
    localparam int ELEM_W    = 4;
    localparam int MAX_SWAPS = 6;
    // Width needed to count 0..MAX_SWAPS swaps.
    localparam int SWAPS_W   = $clog2(MAX_SWAPS + 1);

endpackage

// File: rtl/sort4_controller_cmp.sv
// Unsigned 4-bit magnitude comparator producing one-hot greater/equal/less.
module sort4_controller_cmp
    import sort4_controller_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              gt,
    output logic              eq,
    output logic              lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/sort4_controller.sv
// Sequential bubble sort of four 4-bit values. One compare (and optional swap)
// per cycle through a single shared comparator, with early exit on the first
// pass that makes no swap. DESCEND selects the sort direction.
module sort4_controller
    import sort4_controller_pkg::*;
#(
    parameter int DESCEND = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ELEM_W-1:0] din0,
    input  logic [ELEM_W-1:0] din1,
    input  logic [ELEM_W-1:0] din2,
    input  logic [ELEM_W-1:0] din3,
    output logic [ELEM_W-1:0] dout0,
    output logic [ELEM_W-1:0] dout1,
    output logic [ELEM_W-1:0] dout2,
    output logic [ELEM_W-1:0] dout3,
    output logic              busy,
    output logic              done,
    output logic [2:0]        swaps
);

    localparam bit DESC_MODE = (DESCEND != 0);

    state_t              state_reg, state_next;
    logic [ELEM_W-1:0]   dout_reg [N_ELEM];
    logic [ELEM_W-1:0]   din_arr  [N_ELEM];
    logic [SWAPS_W-1:0]  swaps_reg, swaps_next;
    logic [1:0]          pass_reg, pass_next;
    logic [1:0]          idx_reg, idx_next;
    logic                flag_reg, flag_next;

    logic [1:0]          idx_plus1;
    logic [ELEM_W-1:0]   cmp_a, cmp_b;
    logic                cmp_gt, cmp_eq, cmp_lt;
    logic                load;
    logic                do_swap;
    logic                last_idx;
    logic                pass_swapped;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    // Operands for the shared comparator are the adjacent pair selected by idx.
    assign idx_plus1 = idx_reg + 2'd1;
    assign cmp_a     = dout_reg[idx_reg];
    assign cmp_b     = dout_reg[idx_plus1];

    sort4_controller_cmp u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // Equal pairs never swap, which keeps the sort stable.
    assign load         = (state_reg == IDLE) && start;
    assign do_swap      = (state_reg == SORT) && !cmp_eq && (DESC_MODE ? cmp_lt : cmp_gt);
    // Pass p ends at idx = 2 - p.
    assign last_idx     = (idx_reg == (2'd2 - pass_reg));
    assign pass_swapped = flag_reg | do_swap;

    // Per-element working register: load on accept, exchange on swap.
    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_elem
            logic [ELEM_W-1:0] elem_next;

            // Select the element's next value from load data or the swapped pair.
            always_comb begin
                elem_next = dout_reg[gi];
                if (load) begin
                    elem_next = din_arr[gi];
                end else if (do_swap) begin
                    if (idx_reg == 2'(gi)) begin
                        elem_next = cmp_b;
                    end else if (idx_plus1 == 2'(gi)) begin
                        elem_next = cmp_a;
                    end
                end
            end

            // Element storage, cleared immediately by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_reg[gi] <= '0;
                end else begin
                    dout_reg[gi] <= elem_next;
                end
            end
        end
    endgenerate

    // Next-state, pass/index sequencing and swap counting.
    always_comb begin
        state_next = state_reg;
        swaps_next = swaps_reg;
        pass_next  = pass_reg;
        idx_next   = idx_reg;
        flag_next  = flag_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SORT;
                    swaps_next = '0;
                    pass_next  = 2'd0;
                    idx_next   = 2'd0;
                    flag_next  = 1'b0;
                end
            end
            SORT: begin
                if (do_swap) begin
                    swaps_next = swaps_reg + 1'b1;
                end
                if (last_idx) begin
                    // Finish on a swap-free pass or after the final pass.
                    if (!pass_swapped || pass_reg == 2'd2) begin
                        state_next = DONE;
                    end else begin
                        pass_next = pass_reg + 2'd1;
                        idx_next  = 2'd0;
                        flag_next = 1'b0;
                    end
                end else begin
                    idx_next  = idx_plus1;
                    flag_next = pass_swapped;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            swaps_reg <= '0;
            pass_reg  <= 2'd0;
            idx_reg   <= 2'd0;
            flag_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            swaps_reg <= swaps_next;
            pass_reg  <= pass_next;
            idx_reg   <= idx_next;
            flag_reg  <= flag_next;
        end
    end

    assign dout0 = dout_reg[0];
    assign dout1 = dout_reg[1];
    assign dout2 = dout_reg[2];
    assign dout3 = dout_reg[3];
    assign swaps = swaps_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_sort4_controller.sv
// Self-checking bench: ascending and descending instances, directed cases
// plus random operands checked against a rank/inversion-based reference.
module tb_sort4_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_d = 1'b0;
    logic [3:0] din [4];

    logic [3:0] a_dout0, a_dout1, a_dout2, a_dout3;
    logic [3:0] d_dout0, d_dout1, d_dout2, d_dout3;
    logic       a_busy, a_done, d_busy, d_done;
    logic [2:0] a_swaps, d_swaps;

    bit         sel_desc = 1'b0;
    logic [3:0] obs_dout [4];
    logic       obs_busy, obs_done;
    logic [2:0] obs_swaps;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    sort4_controller #(.DESCEND(0)) u_asc (
        .clk(clk), .rst(rst), .start(start_a),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .dout0(a_dout0), .dout1(a_dout1), .dout2(a_dout2), .dout3(a_dout3),
        .busy(a_busy), .done(a_done), .swaps(a_swaps)
    );

    sort4_controller #(.DESCEND(1)) u_dsc (
        .clk(clk), .rst(rst), .start(start_d),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .dout0(d_dout0), .dout1(d_dout1), .dout2(d_dout2), .dout3(d_dout3),
        .busy(d_busy), .done(d_done), .swaps(d_swaps)
    );

    assign obs_dout[0] = sel_desc ? d_dout0 : a_dout0;
    assign obs_dout[1] = sel_desc ? d_dout1 : a_dout1;
    assign obs_dout[2] = sel_desc ? d_dout2 : a_dout2;
    assign obs_dout[3] = sel_desc ? d_dout3 : a_dout3;
    assign obs_busy    = sel_desc ? d_busy  : a_busy;
    assign obs_done    = sel_desc ? d_done  : a_done;
    assign obs_swaps   = sel_desc ? d_swaps : a_swaps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: output position = stable rank; swaps = strict inversions;
    // passes with a swap = largest number of out-of-order predecessors of any
    // element, plus one swap-free pass unless all three passes are used.
    function automatic bit ahead(input bit desc, input logic [3:0] x, input logic [3:0] y);
        return desc ? (x < y) : (x > y);
    endfunction

    task automatic model(input bit desc, input logic [3:0] d[4],
                         output logic [3:0] s[4], output int sw, output int lat);
        int maxd, k, pos, passes, compares;
        sw = 0;
        maxd = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            for (int j = 0; j < i; j++) begin
                if (ahead(desc, d[j], d[i])) k++;
            end
            sw += k;
            if (k > maxd) maxd = k;
        end
        for (int i = 0; i < 4; i++) begin
            pos = 0;
            for (int j = 0; j < 4; j++) begin
                if (ahead(desc, d[i], d[j]) || (d[j] == d[i] && j < i)) pos++;
            end
            s[pos] = d[i];
        end
        passes   = (maxd + 1 > 3) ? 3 : maxd + 1;
        compares = (passes == 1) ? 3 : (passes == 2) ? 5 : 6;
        lat      = compares + 1;
    endtask

    task automatic set_start(input bit desc, input logic v);
        if (desc) start_d = v;
        else      start_a = v;
    endtask

    // One sort transaction; latency counts cycles after the accept edge,
    // the first cycle being 1, up to and including the done cycle.
    task automatic run_sort(input bit desc, input logic [3:0] d[4], input bit pulse_mid);
        logic [3:0] exp_d [4];
        int exp_sw, exp_lat, lat;
        bit seen;
        model(desc, d, exp_d, exp_sw, exp_lat);
        @(negedge clk);
        sel_desc = desc;
        for (int i = 0; i < 4; i++) din[i] = d[i];
        set_start(desc, 1'b1);
        @(posedge clk);
        lat = 0;
        seen = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) set_start(desc, 1'b0);
            if (pulse_mid && c == 2) set_start(desc, 1'b1);
            if (pulse_mid && c == 3) set_start(desc, 1'b0);
            if (obs_done) begin
                seen = 1;
                lat  = c;
            end else begin
                check("sort_busy", obs_busy, 1);
            end
        end
        check("latency", lat, exp_lat);
        check("done_busy", obs_busy, 1);
        for (int i = 0; i < 4; i++) check($sformatf("dout%0d", i), obs_dout[i], exp_d[i]);
        check("swaps", obs_swaps, exp_sw);
        @(negedge clk);
        check("idle_done", obs_done, 0);
        check("idle_busy", obs_busy, 0);
        @(negedge clk);
        check("not_queued", obs_busy, 0);
        check("hold_dout0", obs_dout[0], exp_d[0]);
        check("hold_swaps", obs_swaps, exp_sw);
        $display("sort desc=%0d in=(%0d,%0d,%0d,%0d) out=(%0d,%0d,%0d,%0d) swaps=%0d lat=%0d",
                 desc, d[0], d[1], d[2], d[3], obs_dout[0], obs_dout[1], obs_dout[2],
                 obs_dout[3], obs_swaps, lat);
    endtask

    initial begin
        logic [3:0] v [4];
        logic [3:0] exp_d [4];
        int exp_sw, exp_lat, dones, extra;

        for (int i = 0; i < 4; i++) din[i] = 4'd0;
        #2;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_dout0", a_dout0, 0);
        check("rst_swaps", a_swaps, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        v = '{4'd9, 4'd3, 4'd7, 4'd1};    run_sort(0, v, 0);
        v = '{4'd0, 4'd5, 4'd5, 4'd15};   run_sort(0, v, 0);
        v = '{4'd2, 4'd8, 4'd8, 4'd4};    run_sort(1, v, 0);
        v = '{4'd15, 4'd14, 4'd13, 4'd12}; run_sort(0, v, 1);
        v = '{4'd0, 4'd15, 4'd0, 4'd15};  run_sort(1, v, 0);

        // Reset during a sort: outputs clear at once, no done pulse follows
        @(negedge clk);
        sel_desc = 0;
        din[0] = 4'd15; din[1] = 4'd14; din[2] = 4'd13; din[3] = 4'd12;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", a_busy, 0);
        check("midrst_done", a_done, 0);
        check("midrst_dout0", a_dout0, 0);
        check("midrst_dout3", a_dout3, 0);
        check("midrst_swaps", a_swaps, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_done || a_busy) dones++;
        end
        check("midrst_quiet", dones, 0);
        $display("reset mid-sort: outputs cleared, idle afterwards");
        v = '{4'd9, 4'd3, 4'd7, 4'd1};    run_sort(0, v, 0);

        // Randomized operands and direction
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
            run_sort(bit'($urandom_range(0, 1)), v, 0);
        end

        // start held high through two sorts
        for (int i = 0; i < 4; i++) v[i] = 4'($urandom_range(0, 15));
        model(0, v, exp_d, exp_sw, exp_lat);
        @(negedge clk);
        sel_desc = 0;
        for (int i = 0; i < 4; i++) din[i] = v[i];
        start_a = 1'b1;
        dones = 0;
        for (int c = 0; c < 40 && dones < 2; c++) begin
            @(negedge clk);
            if (a_done) begin
                dones++;
                check("b2b_dout0", a_dout0, exp_d[0]);
                check("b2b_swaps", a_swaps, exp_sw);
                if (dones == 1) begin
                    @(negedge clk);
                    check("b2b_gap_idle", a_busy, 0);
                    @(negedge clk);
                    check("b2b_relaunch", a_busy, 1);
                    start_a = 1'b0;
                end
            end
        end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_done) extra++;
        end
        check("b2b_done_count", dones + extra, 2);
        $display("back-to-back: %0d done pulses", dones + extra);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sort4_controller.md
SORT4_CONTROLLER -- requirements
Module: sort4_controller

Interface
REQ-001 SHALL have parameter DESCEND, default 0, where 0 sorts ascending and 1 sorts descending.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to load and sort; sampled only in IDLE.
REQ-005 SHALL have ports din0..din3  input  4 each  unsigned operands, captured when start is accepted.
REQ-006 SHALL have ports dout0..dout3  output  4 each  working/result registers; dout0 holds the first element of the sorted order.
REQ-007 SHALL have port busy  output  1  high in SORT and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse, high only in DONE.
REQ-009 SHALL have port swaps  output  3  number of swaps performed in the current/last sort, range 0..6.

Function
REQ-010 SHALL implement FSM states IDLE, SORT, DONE.
REQ-011 In IDLE with start=1, SHALL load din0..din3 into dout0..dout3, clear swaps, set pass=0 and idx=0, and go to SORT on that edge.
REQ-012 In IDLE with start=0, SHALL hold all registers.
REQ-013 In SORT, SHALL perform exactly one comparison per cycle of dout[idx] against dout[idx+1] using one shared 4-bit magnitude comparator (G/E/L).
REQ-014 Ascending: SHALL swap the pair when G=1. Descending: SHALL swap the pair when L=1. SHALL never swap when E=1, so the sort is stable.
REQ-015 Each swap SHALL complete in the same edge as its comparison and increment swaps by 1.
REQ-016 Pass p SHALL visit idx = 0 .. 2-p; pass 0 has 3 compares, pass 1 has 2, pass 2 has 1.
REQ-017 SHALL keep a per-pass swap flag; at the last idx of a pass, if no swap occurred in that pass including the current compare, SHALL go to DONE (early exit).
REQ-018 Otherwise, at the end of pass 2, SHALL go to DONE; the maximum SORT duration is 6 cycles.
REQ-019 Latency from the start-accept edge to the done pulse SHALL be 4 cycles for already-sorted input and 7 cycles worst case.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE; dout and swaps SHALL hold until the next accepted start.
REQ-021 start asserted in SORT or DONE SHALL be ignored and not queued.
REQ-022 start held high continuously SHALL re-launch a sort on the first IDLE cycle after DONE.
REQ-023 All comparisons SHALL be unsigned; values 0 and 15 SHALL be valid boundary inputs.

Reset
REQ-024 rst=1 SHALL immediately force IDLE and set dout0..3=0, swaps=0, busy=0, done=0, and pass/idx/flag=0, including during a sort in progress.
REQ-025 After rst deasserts, the first start SHALL be accepted on the next rising edge at which start=1.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, SORT=2'd1, DONE=2'd2) and the constants N_ELEM=4, ELEM_W=4, MAX_SWAPS=6.
REQ-027 SHALL instantiate the existing 4-bit comparator module exactly once as its only sub-module; operands SHALL be muxed by idx.
REQ-028 Outputs SHALL be driven directly from registers, and busy/done SHALL be decoded from the state register only.

Verification
REQ-029 Ascending, din=(9,3,7,1), start -> done 7 cycles after accept; dout=(1,3,7,9); swaps=5.
REQ-030 Ascending, din=(0,5,5,15), start -> done after 4 cycles; dout unchanged; swaps=0.
REQ-031 DESCEND=1, din=(2,8,8,4), start -> dout=(8,8,4,2); equal elements are not swapped; swaps=3.
REQ-032 Ascending, din=(15,14,13,12) -> dout=(12,13,14,15); swaps=6; start pulsed mid-sort is ignored.
REQ-033 rst asserted 2 cycles into a sort -> all outputs 0 and IDLE in the same cycle, with no done pulse; a new start afterwards sorts correctly.
REQ-034 start held high through 2 sorts -> exactly 2 done pulses, with one IDLE cycle between each done and the next SORT.
